ysyx_25060170_ifetch_buf: RTL and testbench

//  Instruction-fetch stage sitting directly downstream of the PC generator.

---
 rtl/ysyx_25060170_ifetch_buf.sv | 189 ++++++++++++++++++
 tb/tb_ysyx_25060170_ifetch_buf.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060170_ifetch_buf.sv
// ----------------------------------------------------------------------------
// ysyx_25060170_ifetch_buf
//
// Instruction-fetch stage placed directly after the PC generator. It accepts
// one PC per handshake and keeps at most one read outstanding on the
// instruction-memory bus. Each returned {pc, inst} pair goes into a small
// FIFO, which feeds decode over valid/ready. pc_ready_o is the PC
// generator's advance-enable.
//
// Optional build macro:
//   IFETCH_ALIGN_CHECK_EN - if defined, an accepted PC with pc_i[1:0] != 0
//   sends no memory request. Instead it pushes {pc_i, inst=0, fault=1}
//   directly. If undefined, inst_fault_o is tied to 0.
//
// Ports:
//   clk              sole clock, rising edge
//   rst              synchronous reset, active low
//   pc_i/pc_valid_i  fetch address from the PC generator
//   pc_ready_o       PC accepted when pc_valid_i & pc_ready_o
//   mem_req_*        read request (valid/ready, address)
//   mem_rsp_*        read response (one valid pulse per request)
//   flush_i          discard all queued and in-flight fetches
//   inst_valid_o/inst_ready_i  FIFO head handshake toward decode
//   inst_o/inst_pc_o/inst_fault_o  FIFO head fields
// ----------------------------------------------------------------------------
module ysyx_25060170_ifetch_buf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    output logic              pc_ready_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_rsp_valid_i,
    input  logic [DATA_W-1:0] mem_rsp_data_i,
    input  logic              flush_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_fault_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_kill;

    logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
    logic [DATA_W-1:0] r_inst_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;

    logic              w_pc_fire;
    logic              w_misalign;
    logic              w_rsp_push;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_push_pc;
    logic [DATA_W-1:0] w_push_inst;

    // A FIFO slot is reserved when a PC is accepted. Only this fetch can push
    // before it completes, so a later push can never overflow.
    assign pc_ready_o = (r_state == S_IDLE) && (r_count < DEPTH_C) && !flush_i;
    assign w_pc_fire  = pc_valid_i && pc_ready_o;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign w_misalign = w_pc_fire && (pc_i[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Once raised, the request stays up until it is taken, even across a
    // flush. The killed response is dropped on return.
    assign mem_req_valid_o = (r_state == S_REQ);
    assign mem_req_addr_o  = (r_state == S_REQ) ? r_req_pc : '0;

    assign w_rsp_push = (r_state == S_WAIT) && mem_rsp_valid_i && !r_kill && !flush_i;
    assign w_push     = w_rsp_push || w_misalign;
    assign inst_valid_o = (r_count != '0);
    assign w_pop      = inst_valid_o && inst_ready_i;

    // NOTE: every signal written in always_comb gets a default value first.
    // This keeps the block latch-free whatever the branches below do.
    always_comb begin
        w_push_pc   = r_req_pc;
        w_push_inst = mem_rsp_data_i;
        if (w_misalign) begin
            w_push_pc   = pc_i;
            w_push_inst = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_req_pc <= '0;
            r_kill   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_kill <= 1'b0;
                    if (w_pc_fire && !w_misalign) begin
                        r_state  <= S_REQ;
                        r_req_pc <= pc_i;
                    end
                end
                S_REQ: begin
                    if (flush_i) r_kill <= 1'b1;
                    if (mem_req_ready_i) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        // A response arriving with flush is dropped by w_rsp_push.
                        r_state <= S_IDLE;
                        r_kill  <= 1'b0;
                    end else if (flush_i) begin
                        r_kill <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the entry storage is reset on purpose. The head fields are driven
    // straight from the entry at r_rptr, so after reset they must read as 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]   <= '0;
                r_inst_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_pc_mem[r_wptr]   <= w_push_pc;
                r_inst_mem[r_wptr] <= w_push_inst;
                r_wptr             <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign inst_o    = r_inst_mem[r_rptr];
    assign inst_pc_o = r_pc_mem[r_rptr];

`ifdef IFETCH_ALIGN_CHECK_EN
    logic r_fault_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_fault_mem[i] <= 1'b0;
        end else if (w_push && !flush_i) begin
            r_fault_mem[r_wptr] <= w_misalign;
        end
    end

    assign inst_fault_o = r_fault_mem[r_rptr];
`else
    assign inst_fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_25060170_ifetch_buf.sv
// ----------------------------------------------------------------------------
// Directed bench for ysyx_25060170_ifetch_buf (DEPTH=2).
// Inputs are driven 1 time unit after each rising edge, and outputs are
// sampled at the same point. Every expected value is written out by hand.
// ----------------------------------------------------------------------------
module tb_ysyx_25060170_ifetch_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic        flush_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_fault_o;

    int n_total = 0;
    int n_bad   = 0;

    ysyx_25060170_ifetch_buf #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .pc_i            (pc_i),
        .pc_valid_i      (pc_valid_i),
        .pc_ready_o      (pc_ready_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .flush_i         (flush_i),
        .inst_valid_o    (inst_valid_o),
        .inst_ready_i    (inst_ready_i),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .inst_fault_o    (inst_fault_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a PC, then step it through a zero-wait memory. pop_at_rsp raises
    // inst_ready_i during the response cycle.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic pop_at_rsp);
        int n;
        pc_i       = addr;
        pc_valid_i = 1'b1;
        n = 0;
        while (!pc_ready_o && n < 20) begin
            tick();
            n++;
        end
        check("fetch_pc_ready", pc_ready_o, 1);
        tick();
        pc_valid_i = 1'b0;
        pc_i       = '0;
        check("fetch_req_valid", mem_req_valid_o, 1);
        check("fetch_req_addr", mem_req_addr_o, addr);
        tick();
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = data;
        inst_ready_i    = pop_at_rsp;
        tick();
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        inst_ready_i    = 1'b0;
    endtask

    task automatic pop_one();
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0; pc_i = '0; pc_valid_i = 1'b0; mem_req_ready_i = 1'b1;
        mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0; flush_i = 1'b0; inst_ready_i = 1'b0;

        // Reset
        tick(); tick();
        check("rst_req_valid", mem_req_valid_o, 0);
        check("rst_inst_valid", inst_valid_o, 0);
        rst = 1'b1;
        #1;
        check("rst_pc_ready", pc_ready_o, 1);
        check("rst_inst", inst_o, 0);
        check("rst_inst_pc", inst_pc_o, 0);
        check("rst_req_addr", mem_req_addr_o, 0);
        check("rst_fault", inst_fault_o, 0);

        // Single fetch, with the latency checked cycle by cycle
        pc_i = 32'h8000_0000; pc_valid_i = 1'b1;
        tick();                               // accept edge (N)
        pc_valid_i = 1'b0;
        check("sf_req_valid_n1", mem_req_valid_o, 1);
        check("sf_req_addr_n1", mem_req_addr_o, 32'h8000_0000);
        check("sf_pc_ready_req", pc_ready_o, 0);
        tick();                               // request taken
        check("sf_req_valid_n2", mem_req_valid_o, 0);
        mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h0010_0073;
        check("sf_inst_valid_n2", inst_valid_o, 0);
        tick();
        mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
        check("sf_inst_valid_n3", inst_valid_o, 1);
        check("sf_inst", inst_o, 32'h0010_0073);
        check("sf_inst_pc", inst_pc_o, 32'h8000_0000);
        check("sf_fault", inst_fault_o, 0);
        check("sf_pc_ready_after", pc_ready_o, 1);
        pop_one();
        check("sf_popped", inst_valid_o, 0);

        // Backpressure: two entries queued, pc_ready_o low until a pop
        fetch(32'h8000_0000, 32'h0000_0111, 1'b0);
        fetch(32'h8000_0004, 32'h0000_0222, 1'b0);
        check("bp_full_pc_ready", pc_ready_o, 0);
        check("bp_head_pc0", inst_pc_o, 32'h8000_0000);
        check("bp_head_inst0", inst_o, 32'h0000_0111);
        pc_i = 32'h8000_0008; pc_valid_i = 1'b1;
        tick();
        check("bp_no_accept", mem_req_valid_o, 0);
        check("bp_still_full", pc_ready_o, 0);
        pc_valid_i = 1'b0;
        pop_one();
        check("bp_pc_ready_after_pop", pc_ready_o, 1);
        check("bp_head_pc1", inst_pc_o, 32'h8000_0004);
        check("bp_head_inst1", inst_o, 32'h0000_0222);
        pop_one();
        check("bp_empty", inst_valid_o, 0);

        // Push and pop in the same cycle: count stays 1, head advances
        fetch(32'h8000_0060, 32'h0000_00aa, 1'b0);
        fetch(32'h8000_0064, 32'h0000_00bb, 1'b1);
        check("pp_valid", inst_valid_o, 1);
        check("pp_head_pc", inst_pc_o, 32'h8000_0064);
        check("pp_head_inst", inst_o, 32'h0000_00bb);
        pop_one();
        check("pp_empty", inst_valid_o, 0);

        // Flush in WAIT with one entry queued; the response arrives 3 cycles later
        fetch(32'h8000_0040, 32'h0000_0011, 1'b0);
        pc_i = 32'h8000_0010; pc_valid_i = 1'b1;
        tick();
        pc_valid_i = 1'b0;
        tick();                               // now in WAIT
        flush_i = 1'b1;
        #1;
        check("fw_pc_ready_flush", pc_ready_o, 0);
        tick();
        flush_i = 1'b0;
        check("fw_fifo_emptied", inst_valid_o, 0);
        check("fw_no_req", mem_req_valid_o, 0);
        check("fw_still_wait", pc_ready_o, 0);
        tick(); tick();
        mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h0000_0022;
        tick();
        mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
        check("fw_dropped", inst_valid_o, 0);
        check("fw_idle", pc_ready_o, 1);
        fetch(32'h8000_0020, 32'h0000_0033, 1'b0);
        check("fw_next_valid", inst_valid_o, 1);
        check("fw_next_pc", inst_pc_o, 32'h8000_0020);
        check("fw_next_inst", inst_o, 32'h0000_0033);
        pop_one();

        // Flush in REQ while the memory stalls for 4 cycles
        mem_req_ready_i = 1'b0;
        pc_i = 32'h8000_0030; pc_valid_i = 1'b1;
        tick();
        pc_valid_i = 1'b0;
        flush_i = 1'b1;
        check("fr_req_valid_0", mem_req_valid_o, 1);
        tick();
        flush_i = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check($sformatf("fr_req_valid_%0d", i), mem_req_valid_o, 1);
            check($sformatf("fr_req_addr_%0d", i), mem_req_addr_o, 32'h8000_0030);
            tick();
        end
        mem_req_ready_i = 1'b1;
        check("fr_req_valid_4", mem_req_valid_o, 1);
        tick();
        check("fr_req_done", mem_req_valid_o, 0);
        mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h0000_0044;
        tick();
        mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
        check("fr_dropped", inst_valid_o, 0);
        check("fr_idle", pc_ready_o, 1);

        // A response while IDLE is ignored
        mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h0000_0055;
        tick();
        mem_rsp_valid_i = 1'b0;
        check("idle_rsp_ignored", inst_valid_o, 0);

        // Reset in the middle of a fetch, with one entry queued
        fetch(32'h8000_0070, 32'h0000_0077, 1'b0);
        pc_i = 32'h8000_0050; pc_valid_i = 1'b1;
        tick();
        pc_valid_i = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mr_req_valid", mem_req_valid_o, 0);
        check("mr_inst_valid", inst_valid_o, 0);
        check("mr_pc_ready", pc_ready_o, 1);
        check("mr_inst", inst_o, 0);
        mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h0000_0088;
        tick();
        mem_rsp_valid_i = 1'b0;
        check("mr_late_rsp", inst_valid_o, 0);

`ifdef IFETCH_ALIGN_CHECK_EN
        // A misaligned PC pushes a fault entry and sends no request
        pc_i = 32'h8000_0002; pc_valid_i = 1'b1;
        tick();
        pc_valid_i = 1'b0;
        check("al_no_req", mem_req_valid_o, 0);
        check("al_valid", inst_valid_o, 1);
        check("al_fault", inst_fault_o, 1);
        check("al_pc", inst_pc_o, 32'h8000_0002);
        check("al_inst", inst_o, 0);
        check("al_idle", pc_ready_o, 1);
        pop_one();
        check("al_empty", inst_valid_o, 0);
`else
        // Without the alignment check, a misaligned PC is fetched normally
        fetch(32'h8000_0002, 32'h0000_0099, 1'b0);
        check("na_pc", inst_pc_o, 32'h8000_0002);
        check("na_fault", inst_fault_o, 0);
        pop_one();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
